// File: rtl/udp_pair_checker_if.sv
// Bundle between the UDP pair test harness (master) and udp_pair_checker (slave).
interface udp_pair_checker_if #(
    parameter int NCYC  = 90,
    parameter int ERR_W = 8
);
    localparam int KW = $clog2(NCYC + 1);

    logic             start;
    logic             stim;
    logic             o_inv;
    logic             o_buf;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [KW-1:0]    first_err_cyc;

    modport master (
        output start, stim, o_inv, o_buf,
        input  busy, done, pass, err_count, first_err_cyc
    );

    modport slave (
        input  start, stim, o_inv, o_buf,
        output busy, done, pass, err_count, first_err_cyc
    );
endinterface

// File: rtl/udp_pair_checker.sv
// Checks a complementary UDP pair against the LAT-delayed stimulus over an NCYC-cycle run.
// Optional first-mismatch capture is enabled by defining UDP_PAIR_CHK_FIRST_ERR_EN.
module udp_pair_checker #(
    parameter int NCYC  = 90,
    parameter int LAT   = 1,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    udp_pair_checker_if.slave  bus
);
    localparam int KW = $clog2(NCYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [LAT-1:0]   dl;
    logic [ERR_W-1:0] err_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             d;
    logic             mism;
    logic             last;

`ifdef UDP_PAIR_CHK_FIRST_ERR_EN
    logic [KW-1:0]    ferr_q;
    logic             ferr_seen;
`endif

    // dl[LAT-1] holds stim from LAT cycles ago; warm-up cycles are never compared.
    always_comb begin
        d    = dl[LAT-1];
        mism = (state == RUN) && (k >= KW'(LAT)) &&
               ((bus.o_inv != ~d) || (bus.o_buf != d));
        last = (k == KW'(NCYC - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            dl     <= '0;
            err_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
`ifdef UDP_PAIR_CHK_FIRST_ERR_EN
            ferr_q    <= '0;
            ferr_seen <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        k      <= '0;
                        dl     <= '0;
                        err_q  <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        pass_q <= 1'b0;
`ifdef UDP_PAIR_CHK_FIRST_ERR_EN
                        ferr_q    <= '0;
                        ferr_seen <= 1'b0;
`endif
                    end
                end
                RUN: begin
                    dl[0] <= bus.stim;
                    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
                    if (mism && (err_q != '1)) err_q <= err_q + 1'b1;
`ifdef UDP_PAIR_CHK_FIRST_ERR_EN
                    if (mism && !ferr_seen) begin
                        ferr_q    <= k;
                        ferr_seen <= 1'b1;
                    end
`endif
                    // The last compare is folded into the verdict on the same edge.
                    if (last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= (err_q == '0) && !mism;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
`ifdef UDP_PAIR_CHK_FIRST_ERR_EN
    assign bus.first_err_cyc = ferr_q;
`else
    assign bus.first_err_cyc = '0;
`endif
endmodule
